// File: rtl/fm_add_flow_seq.sv
// fm_add_flow_seq: sequences the DDR/BRAM transfer engines through a masked six-step flow
module fm_add_flow_seq #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STEP_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_calib_complete,
  input  logic       start,
  input  logic [5:0] step_mask,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_step,
  output logic [2:0] cur_step,
  output logic       en_d2o,
  output logic       rd_wr_d2o,
  input  logic       done_d2o,
  output logic       en_db,
  output logic       rd_wr_db,
  input  logic       done_db,
  output logic       en_b2o,
  output logic       rd_wr_b2o,
  output logic       bram_sel_b2o,
  input  logic       done_b2o,
  output logic       bram_cs,
  output logic [1:0] ddr_sel
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(STEP_GAP + 1);
  typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT, FINISH} state_t;
  state_t state, state_n;
  logic [5:0] mask_q, mask_n;
  logic [2:0] step_n, err_step_n, load_step;
  logic [1:0] eng_q, eng_n;
  logic rw_q, rw_n, bsel_n, cs_n, error_n;
  logic [GW-1:0] gap_q, gap_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic [3:0] first_s, next_s;
  logic load, timeout, sel_done;
  logic [4:0] cfg;
  function automatic logic [3:0] first_set(input logic [5:0] m, input logic [2:0] lo);
    first_set = 4'd0;
    for (int i = 5; i >= 0; i--)
      if (m[i] && 3'(i) >= lo) first_set = {1'b1, 3'(i)};
  endfunction
  // step table entry: {engine (1 d2o, 2 db, 3 b2o), rd_wr, bram_sel, bram_cs}
  function automatic logic [4:0] step_cfg(input logic [2:0] s);
    case (s)
      3'd0:    step_cfg = 5'b01_1_0_0;
      3'd1:    step_cfg = 5'b10_0_0_0;
      3'd2:    step_cfg = 5'b11_0_0_0;
      3'd3:    step_cfg = 5'b11_1_1_1;
      3'd4:    step_cfg = 5'b10_1_0_1;
      default: step_cfg = 5'b01_0_0_0;
    endcase
  endfunction
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign en_d2o = state == LAUNCH && eng_q == 2'd1;
  assign en_db = state == LAUNCH && eng_q == 2'd2;
  assign en_b2o = state == LAUNCH && eng_q == 2'd3;
  assign rd_wr_d2o = rw_q && eng_q == 2'd1;
  assign rd_wr_db = rw_q && eng_q == 2'd2;
  assign rd_wr_b2o = rw_q && eng_q == 2'd3;
  assign ddr_sel = eng_q == 2'd3 ? 2'b00 : eng_q;
  assign sel_done = eng_q == 2'd1 ? done_d2o : eng_q == 2'd2 ? done_db : eng_q == 2'd3 ? done_b2o : 1'b0;
  assign first_s = first_set(step_mask, 3'd0);
  assign next_s = first_set(mask_q, cur_step + 3'd1);
  assign cfg = step_cfg(load_step);
  // next-state and next-register values; abort beats done, done beats timeout
  always_comb begin
    state_n = state;
    mask_n = mask_q;
    step_n = cur_step;
    eng_n = eng_q;
    rw_n = rw_q;
    bsel_n = bram_sel_b2o;
    cs_n = bram_cs;
    gap_n = gap_q;
    tcnt_n = tcnt_q;
    error_n = error;
    err_step_n = err_step;
    load = 1'b0;
    load_step = next_s[2:0];
    timeout = 1'b0;
    if (state != IDLE && abort) state_n = IDLE;
    else case (state)
      IDLE: if (start && init_calib_complete) begin
        mask_n = step_mask;
        error_n = 1'b0;
        err_step_n = 3'd0;
        load = first_s[3];
        load_step = first_s[2:0];
        state_n = first_s[3] ? SETUP : FINISH;
      end
      SETUP: if (!init_calib_complete) timeout = 1'b1;
        else if (gap_q == GW'(STEP_GAP - 1)) state_n = LAUNCH;
        else gap_n = gap_q + 1'b1;
      LAUNCH: if (!init_calib_complete) timeout = 1'b1;
        else begin
          tcnt_n = '0;
          state_n = WAIT;
        end
      WAIT: if (sel_done) begin
          load = next_s[3];
          state_n = next_s[3] ? SETUP : FINISH;
        end else begin
          tcnt_n = tcnt_q + 1'b1;
          timeout = !init_calib_complete || tcnt_q == TW'(TIMEOUT_CYCLES - 1);
        end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      error_n = 1'b1;
      err_step_n = cur_step;
      state_n = FINISH;
    end
    if (load) begin
      step_n = load_step;
      {eng_n, rw_n, bsel_n, cs_n} = cfg;
      gap_n = '0;
    end
    if (state_n == IDLE) begin
      step_n = 3'd0;
      eng_n = 2'd0;
      rw_n = 1'b0;
      bsel_n = 1'b0;
      cs_n = 1'b0;
    end
  end
  // state and step-configuration registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mask_q <= '0;
      cur_step <= '0;
      eng_q <= '0;
      rw_q <= 1'b0;
      bram_sel_b2o <= 1'b0;
      bram_cs <= 1'b0;
      gap_q <= '0;
      tcnt_q <= '0;
      error <= 1'b0;
      err_step <= '0;
    end else begin
      state <= state_n;
      mask_q <= mask_n;
      cur_step <= step_n;
      eng_q <= eng_n;
      rw_q <= rw_n;
      bram_sel_b2o <= bsel_n;
      bram_cs <= cs_n;
      gap_q <= gap_n;
      tcnt_q <= tcnt_n;
      error <= error_n;
      err_step <= err_step_n;
    end
endmodule
